// File: rtl/abus_pkg.sv
// Shared types and helpers for the abus interconnect blocks.
package abus_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } abus_wrr_state_t;

  // Binary index of a one-hot vector (up to 64 requesters); all-zero maps to 0.
  function automatic logic [5:0] onehot_to_idx(input logic [63:0] oh);
    logic [5:0] idx;
    idx = '0;
    for (int i = 0; i < 64; i++) begin
      if (oh[i]) idx = idx | 6'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/abus_rr.sv
// Combinational round-robin picker: returns the first requester at or above
// the one-hot priority position, wrapping around the top.
module abus_rr #(
  parameter int N = 8
) (
  input  logic [N-1:0] req,
  input  logic [N-1:0] prio,
  output logic [N-1:0] gnt
);

  logic [2*N-1:0] dreq;
  logic [2*N-1:0] dgnt;

  // Doubled request vector lets one subtract-and-mask handle the wrap.
  always_comb begin
    dreq = {req, req};
    dgnt = dreq & ~(dreq - {{N{1'b0}}, prio});
    gnt  = dgnt[N-1:0] | dgnt[2*N-1:N];
  end

endmodule

// File: rtl/abus_wrr.sv
// Weighted round-robin arbiter for the abus master-select mux.
//
// state | meaning
// IDLE  | no grant asserted, waiting for any request
// BUSY  | master cur holds the grant; cnt counts cycles beyond the first
module abus_wrr
  import abus_pkg::*;
#(
  parameter  int N  = 8,
  parameter  int WW = 4,
  localparam int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic [N*WW-1:0] weight,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          valid
);

  abus_wrr_state_t state, state_n;
  logic [IW-1:0]   ptr, ptr_n, cur, cur_n, cur_inc, win;
  logic [WW-1:0]   cnt, cnt_n, wlat, wlat_n, wsel;
  logic [N-1:0]    prio, rr_gnt;
  logic            any, rel;

  // Release is decided first so the picker can re-arbitrate from the new pointer in the same cycle.
  always_comb begin
    cur_inc = (cur == IW'(N - 1)) ? '0 : cur + IW'(1);
    rel     = (state == BUSY) && (!req[cur] || (cnt == wlat));
    ptr_n   = rel ? cur_inc : ptr;
    prio    = N'(1) << ptr_n;
    any     = |req;
  end

  abus_rr #(.N(N)) u_rr (
    .req  (req),
    .prio (prio),
    .gnt  (rr_gnt)
  );

  // Winner index and its weight, sampled only when a new burst starts.
  always_comb begin
    win  = IW'(onehot_to_idx(64'(rr_gnt)));
    wsel = weight[win*WW +: WW];
  end

  // Next-state: hold the burst, hand over back-to-back, or fall to idle.
  always_comb begin
    state_n = state;
    cur_n   = cur;
    cnt_n   = cnt;
    wlat_n  = wlat;
    case (state)
      IDLE: begin
        if (any) begin
          state_n = BUSY;
          cur_n   = win;
          wlat_n  = wsel;
          cnt_n   = '0;
        end
      end
      BUSY: begin
        if (!rel) begin
          cnt_n = cnt + WW'(1);
        end else if (any) begin
          cur_n  = win;
          wlat_n = wsel;
          cnt_n  = '0;
        end else begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State registers; reset drops the grant immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
      cur   <= '0;
      cnt   <= '0;
      wlat  <= '0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      cur   <= cur_n;
      cnt   <= cnt_n;
      wlat  <= wlat_n;
    end
  end

  // Outputs decode registered state only, so req has no path to grant.
  always_comb begin
    valid     = (state == BUSY);
    grant     = valid ? (N'(1) << cur) : '0;
    grant_idx = valid ? cur : '0;
  end

endmodule
